// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N producers, the round-robin arbiter/mux and one consumer.
// The slave modport is the arbiter's view; the master modport drives producers and consumer.
interface rr_arb_mux_if #(
    parameter int size     = 16,
    parameter int channels = 4
);
    localparam int IW = $clog2(channels);

    logic [channels*size-1:0] in_data;
    logic [channels-1:0]      in_valid;
    logic [channels-1:0]      in_ready;
    logic                     force_en;
    logic [IW-1:0]            force_sel;
    logic [size-1:0]          out_data;
    logic [IW-1:0]            out_chan;
    logic                     out_valid;
    logic                     out_ready;

    modport slave (
        input  in_data, in_valid, force_en, force_sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output in_data, in_valid, force_en, force_sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/rr_arb_mux.sv
// Registered N:1 mux with round-robin or forced-select arbitration and a single-entry
// output register that reloads whenever it is empty or being drained.
module rr_arb_mux #(
    parameter int size     = 16,
    parameter int channels = 4
) (
    input  logic         clk,
    input  logic         rst,
    rr_arb_mux_if.slave  bus
);
    localparam int IW = $clog2(channels);

    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   cand;
    logic            found;
    logic            load_en;
    logic [size-1:0] sel_data;

    assign load_en = !bus.out_valid || bus.out_ready;

    // Round-robin scan: channels above last_grant first, then wrap to 0..last_grant.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        if (bus.force_en) begin
            for (int i = 0; i < channels; i++) begin
                if (bus.force_sel == IW'(i) && bus.in_valid[i]) begin
                    found = 1'b1;
                    cand  = IW'(i);
                end
            end
        end else begin
            for (int i = 0; i < channels; i++) begin
                if (!found && bus.in_valid[i] && IW'(i) > last_grant) begin
                    found = 1'b1;
                    cand  = IW'(i);
                end
            end
            for (int i = 0; i < channels; i++) begin
                if (!found && bus.in_valid[i] && IW'(i) <= last_grant) begin
                    found = 1'b1;
                    cand  = IW'(i);
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < channels; i++) begin
            if (cand == IW'(i)) sel_data = bus.in_data[i*size +: size];
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < channels; i++) begin
            bus.in_ready[i] = !rst && load_en && found && (cand == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_chan  <= '0;
            last_grant    <= IW'(channels - 1);
        end else if (load_en) begin
            if (found) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= sel_data;
                bus.out_chan  <= cand;
                if (!bus.force_en) last_grant <= cand;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios plus randomized traffic against a
// queue-free behavioural model of the arbitration rules.
module tb_rr_arb_mux;
    logic clk = 1'b0;
    logic rst4, rst3;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rr_arb_mux_if #(.size(16), .channels(4)) b4 ();
    rr_arb_mux_if #(.size(16), .channels(3)) b3 ();

    rr_arb_mux #(.size(16), .channels(4)) dut4 (.clk(clk), .rst(rst4), .bus(b4.slave));
    rr_arb_mux #(.size(16), .channels(3)) dut3 (.clk(clk), .rst(rst3), .bus(b3.slave));

    // Reference model state for the 4-channel instance
    logic        m_v;
    logic [15:0] m_d;
    int          m_c;
    int          m_last;

    function automatic int cand4();
        int fs;
        if (b4.force_en) begin
            fs = int'(b4.force_sel);
            if (fs < 4 && b4.in_valid[fs]) return fs;
            return -1;
        end
        for (int k = 1; k <= 4; k++) begin
            if (b4.in_valid[(m_last + k) % 4]) return (m_last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready4();
        int c;
        c = cand4();
        if (rst4 || (m_v && !b4.out_ready) || c < 0) return 4'b0000;
        return 4'(1 << c);
    endfunction

    task automatic tick4();
        int          c;
        logic        le;
        logic [15:0] w;
        logic        fe;
        c  = cand4();
        le = !m_v || b4.out_ready;
        w  = (c >= 0) ? b4.in_data[c*16 +: 16] : 16'h0;
        fe = b4.force_en;
        @(posedge clk);
        if (rst4) begin
            m_v = 0; m_d = 0; m_c = 0; m_last = 3;
        end else if (le) begin
            if (c >= 0) begin
                m_v = 1; m_d = w; m_c = c;
                if (!fe) m_last = c;
            end else begin
                m_v = 0;
            end
        end
        #1;
    endtask

    task automatic set_all4(input logic [3:0] v, input logic [15:0] base);
        b4.in_valid = v;
        for (int i = 0; i < 4; i++) b4.in_data[i*16 +: 16] = base + 16'(i);
    endtask

    task automatic test_reset();
        rst4 = 1;
        set_all4(4'b1111, 16'h1000);
        b4.force_en = 0; b4.force_sel = 0; b4.out_ready = 1;
        m_v = 0; m_d = 0; m_c = 0; m_last = 3;
        for (int n = 0; n < 2; n++) begin
            #1;
            checks++;
            if (b4.in_ready !== 4'b0000) begin
                errors++; $display("FAIL reset_in_ready: got %b want 0000", b4.in_ready);
            end
            tick4();
        end
        checks++;
        if (b4.out_valid !== 1'b0 || b4.out_data !== 16'h0000 || b4.out_chan !== 2'd0) begin
            errors++;
            $display("FAIL reset_out: got v=%b d=%h c=%0d want v=0 d=0000 c=0",
                     b4.out_valid, b4.out_data, b4.out_chan);
        end
        rst4 = 0;
        #1;
        checks++;
        if (b4.in_ready !== 4'b0001) begin
            errors++; $display("FAIL reset_release_ready: got %b want 0001", b4.in_ready);
        end
    endtask

    task automatic test_round_robin();
        int seq[5] = '{0, 1, 2, 3, 0};
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (b4.in_ready !== exp_ready4()) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b want %b", n, b4.in_ready, exp_ready4());
            end
            tick4();
            checks++;
            if (b4.out_chan !== 2'(seq[n]) || b4.out_data !== 16'h1000 + 16'(seq[n]) || b4.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_out[%0d]: got c=%0d d=%h v=%b want c=%0d d=%h v=1",
                         n, b4.out_chan, b4.out_data, b4.out_valid, seq[n], 16'h1000 + 16'(seq[n]));
            end
            #1;
        end
    endtask

    task automatic test_skip();
        b4.in_valid = 4'b1000;
        b4.in_data[48 +: 16] = 16'hBEEF;
        #1;
        checks++;
        if (b4.in_ready !== 4'b1000) begin
            errors++; $display("FAIL skip_ready: got %b want 1000", b4.in_ready);
        end
        tick4();
        checks++;
        if (b4.out_chan !== 2'd3 || b4.out_data !== 16'hBEEF) begin
            errors++; $display("FAIL skip_out: got c=%0d d=%h want c=3 d=beef", b4.out_chan, b4.out_data);
        end
    endtask

    task automatic test_backpressure();
        set_all4(4'b1111, 16'h1000);
        tick4();
        tick4();
        checks++;
        if (b4.out_data !== 16'h1001 || b4.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_setup: got d=%h v=%b want d=1001 v=1", b4.out_data, b4.out_valid);
        end
        b4.out_ready = 0;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if (b4.in_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", n, b4.in_ready);
            end
            tick4();
            checks++;
            if (b4.out_data !== 16'h1001 || b4.out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d]: got d=%h v=%b want d=1001 v=1", n, b4.out_data, b4.out_valid);
            end
        end
        b4.out_ready = 1;
        #1;
        checks++;
        if (b4.in_ready !== 4'b0100) begin
            errors++; $display("FAIL bp_release_ready: got %b want 0100", b4.in_ready);
        end
        tick4();
        checks++;
        if (b4.out_chan !== 2'd2) begin
            errors++; $display("FAIL bp_release_chan: got %0d want 2", b4.out_chan);
        end
    endtask

    task automatic test_forced();
        int after[2] = '{2, 3};
        tick4(); tick4(); tick4();   // grants 3, 0, 1 -> last_grant = 1
        b4.force_en = 1; b4.force_sel = 2;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if (b4.in_ready !== 4'b0100) begin
                errors++; $display("FAIL force_ready[%0d]: got %b want 0100", n, b4.in_ready);
            end
            tick4();
            checks++;
            if (b4.out_chan !== 2'd2) begin
                errors++; $display("FAIL force_chan[%0d]: got %0d want 2", n, b4.out_chan);
            end
        end
        b4.force_en = 0;
        for (int n = 0; n < 2; n++) begin
            tick4();
            checks++;
            if (b4.out_chan !== 2'(after[n])) begin
                errors++; $display("FAIL unforce_chan[%0d]: got %0d want %0d", n, b4.out_chan, after[n]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst4         = ($urandom_range(0, 99) < 2);
            b4.in_valid  = 4'($urandom);
            b4.in_data   = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            b4.out_ready = ($urandom_range(0, 3) != 0);
            b4.force_en  = ($urandom_range(0, 3) == 0);
            b4.force_sel = 2'($urandom);
            #1;
            checks++;
            if (b4.in_ready !== exp_ready4()) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b want %b", n, b4.in_ready, exp_ready4());
            end
            tick4();
            checks++;
            if (b4.out_valid !== m_v || b4.out_data !== m_d || b4.out_chan !== 2'(m_c)) begin
                errors++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         n, b4.out_valid, b4.out_data, b4.out_chan, m_v, m_d, m_c);
            end
        end
        rst4 = 0;
    endtask

    task automatic test_range_and_reset();
        rst3 = 1;
        b3.in_valid = 3'b111;
        for (int i = 0; i < 3; i++) b3.in_data[i*16 +: 16] = 16'h3000 + 16'(i);
        b3.force_en = 0; b3.force_sel = 0; b3.out_ready = 1;
        @(posedge clk); #1;
        rst3 = 0;
        @(posedge clk); #1;
        checks++;
        if (b3.out_valid !== 1'b1 || b3.out_chan !== 2'd0) begin
            errors++; $display("FAIL r3_first: got v=%b c=%0d want v=1 c=0", b3.out_valid, b3.out_chan);
        end
        b3.force_en = 1; b3.force_sel = 2'd3;
        #1;
        checks++;
        if (b3.in_ready !== 3'b000) begin
            errors++; $display("FAIL r3_oor_ready: got %b want 000", b3.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (b3.out_valid !== 1'b0 || b3.out_data !== 16'h3000 || b3.out_chan !== 2'd0) begin
            errors++;
            $display("FAIL r3_oor_drain: got v=%b d=%h c=%0d want v=0 d=3000 c=0",
                     b3.out_valid, b3.out_data, b3.out_chan);
        end
        b3.force_en = 0; b3.out_ready = 0;
        @(posedge clk); #1;
        checks++;
        if (b3.out_valid !== 1'b1 || b3.out_chan !== 2'd1) begin
            errors++; $display("FAIL r3_load: got v=%b c=%0d want v=1 c=1", b3.out_valid, b3.out_chan);
        end
        rst3 = 1; b3.out_ready = 1;
        #1;
        checks++;
        if (b3.in_ready !== 3'b000) begin
            errors++; $display("FAIL r3_rst_ready: got %b want 000", b3.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (b3.out_valid !== 1'b0 || b3.out_data !== 16'h0000) begin
            errors++; $display("FAIL r3_rst_out: got v=%b d=%h want v=0 d=0000", b3.out_valid, b3.out_data);
        end
        rst3 = 0;
        #1;
        checks++;
        if (b3.in_ready !== 3'b001) begin
            errors++; $display("FAIL r3_rst_release: got %b want 001", b3.in_ready);
        end
    endtask

    initial begin
        rst3 = 1;
        b3.in_valid = '0; b3.in_data = '0; b3.force_en = 0; b3.force_sel = 0; b3.out_ready = 0;
        test_reset();
        test_round_robin();
        test_skip();
        test_backpressure();
        test_forced();
        test_random();
        test_range_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised, registered N:1 data multiplexer with round-robin arbitration and valid/ready handshakes. It generalises the combinational 2:1 select path to `channels` inputs of `size` bits. It has two selection modes: fair round-robin across requesting channels, or a forced fixed select that behaves like a classic mux select. It sits between multiple producers (e.g. register-file read ports, memory/IO return paths) and a single consumer stage of the 16-bit datapath.

## Interface
- `size`, 16: data width of every channel and of the output.
- `channels`, 4: number of input channels; legal range 2..8.
- `IW` (localparam), `$clog2(channels)`: channel index width.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset; synchronous and active-high.
- `in_data`  in  `channels*size`: packed inputs; channel i occupies `[i*size +: size]`.
- `in_valid`  in  `channels`: bit i means channel i presents a word.
- `in_ready`  out  `channels`: bit i means channel i's word is accepted this cycle. This output is combinational.
- `force_en`  in  1: 1 selects forced mode; 0 selects round-robin mode.
- `force_sel`  in  `IW`: channel to select when `force_en`=1.
- `out_data`  out  `size`: registered selected word.
- `out_chan`  out  `IW`: index of the channel that supplied `out_data`.
- `out_valid`  out  1: `out_data`/`out_chan` hold a word.
- `out_ready`  in  1: consumer accepts the word this cycle.

## Operation
- Output register holds one entry. `load_en = !out_valid || out_ready`, which gives full throughput with no bubble.
- Round-robin mode:
  - Search starts at `(last_grant+1) mod channels` and scans upward with wrap-around.
  - The first channel with `in_valid` set is the candidate.
  - Channels without `in_valid` are skipped with no penalty.
- Forced mode:
  - The candidate is `force_sel`, and only if `in_valid[force_sel]` is set. Other channels are never granted.
  - If `force_sel >= channels`, there is no candidate.
- Grant: `in_ready[i] = load_en && candidate_exists && candidate==i`. At most one bit of `in_ready` is set.
- On a grant, at the clock edge:
  - `out_data` ← that channel's word.
  - `out_chan` ← i.
  - `out_valid` ← 1.
- `last_grant` ← i only on grants made in round-robin mode. Forced-mode grants leave `last_grant` unchanged.
- If `load_en` and no candidate: `out_valid` ← 0. `out_data` and `out_chan` hold their old values.
- If `!load_en` (`out_valid`=1, `out_ready`=0): output fields hold, and all `in_ready` are 0.
- `force_en` and `force_sel` are sampled every cycle. Switching modes mid-stream is legal and takes effect on that cycle's grant.

## Timing
- Reset (`rst`=1 at an edge):
  - `out_valid`=0, `out_data`=0, `out_chan`=0.
  - `last_grant`=`channels-1`, so channel 0 has first priority.
  - While `rst`=1, `in_ready` is forced to all 0.
- Reset asserted while `out_valid`=1 discards the held word. No handshake completes in that cycle.
- Latency: a word accepted at edge k appears on `out_data` with `out_valid`=1 immediately after edge k. Minimum latency is 1 cycle.
- Throughput: one word per cycle when `out_ready` stays 1.
- A simultaneous output drain and input accept in the same cycle is the normal case. The new word replaces the old one at the edge.
- `in_ready` depends combinationally on `in_valid`, `out_valid`, `out_ready`, `force_en` and `force_sel`. Producers must not make `in_valid` depend on `in_ready`.
- Handshake: a producer must hold its `in_data`/`in_valid` stable until `in_ready`. The consumer sees `out_data` stable while `out_valid && !out_ready`.

## Test plan
- Reset behaviour (`channels`=4, `size`=16):
  - Hold `rst`=1 for 2 cycles with all `in_valid`=1 → `out_valid`=0, `out_data`=0x0000, `in_ready`=0000.
  - On the first cycle after release → `in_ready`=0001.
- Round-robin order: all four valid with data 0x1000+i, `out_ready`=1 → `out_chan` sequence 0,1,2,3,0 on consecutive cycles, with `out_data` 0x1000,0x1001,0x1002,0x1003,0x1000.
- Skipping idle channels: after a grant to channel 0, only channel 3 valid (data 0xBEEF) → the next cycle shows `in_ready`=1000, and then `out_chan`=3, `out_data`=0xBEEF.
- Backpressure:
  - With `out_valid`=1 and `out_data`=0x1001, hold `out_ready`=0 for 3 cycles → `out_data` stays 0x1001 and `in_ready`=0000 throughout.
  - Raise `out_ready` → channel 2 is granted next.
- Forced mode:
  - `force_en`=1, `force_sel`=2, all valid → only `in_ready[2]` is set; `out_chan`=2 every cycle.
  - Then drop `force_en`, with `last_grant` previously at 1 → next grant is channel 2, then 3.
- Out-of-range select and mid-operation reset:
  - `channels`=3, `force_en`=1, `force_sel`=3 → `in_ready`=000 and `out_valid` falls to 0 after its word drains.
  - Assert `rst` while `out_valid`=1 → `out_valid`=0 at the next edge, and the held word is never handshaken.
